pmux_result_fifo: RTL and testbench

- Downstream buffer stage for the 16-bit priority-mux result.
- Captures the mux output on a strobe and holds it in a small show-ahead FIFO, then hands it to the consumer with a valid/ready handshake.
- Counts results dropped while full so the bench and synthesis flow can check throughput after lowering to combinators.

---
 rtl/pmux_pkg.sv | 6 +
 rtl/pmux_fifo_regfile.sv | 24 ++
 rtl/pmux_result_fifo.sv | 71 +++++++
 tb/tb_pmux_result_fifo.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pmux_pkg.sv
// pmux_pkg: shared sizing constants for the priority-mux result path.
package pmux_pkg;
   localparam int PMUX_WIDTH      = 16;
   localparam int PMUX_FIFO_DEPTH = 4;
   localparam int PMUX_DROP_W     = 8;
endpackage

// File: rtl/pmux_fifo_regfile.sv
// pmux_fifo_regfile: DEPTH x WIDTH register array, one write port, combinational read mux.
// Ports: clk_i/rst_i clock and async reset; we_i/waddr_i/wdata_i write port;
//        raddr_i/rdata_o read address and muxed read data.
module pmux_fifo_regfile import pmux_pkg::*; #(
   parameter int WIDTH = PMUX_WIDTH,
   parameter int DEPTH = PMUX_FIFO_DEPTH
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output logic [WIDTH-1:0]           rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   // Cleared on reset so the array never holds X after lowering.
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i)
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      else if (we_i)
         mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pmux_result_fifo.sv
// pmux_result_fifo: show-ahead result FIFO behind the priority mux with drop counting.
// Ports: clk_i/rst_i clock and async active-high reset;
//        data_i/valid_i/ready_o capture side (rejected writes while full are counted);
//        data_o/valid_o/ready_i consumer handshake (data_o is 0 while empty);
//        count_o occupancy, drop_cnt_o saturating drop count, overflow_o sticky drop flag.
module pmux_result_fifo import pmux_pkg::*; #(
   parameter int WIDTH  = PMUX_WIDTH,
   parameter int DEPTH  = PMUX_FIFO_DEPTH,
   parameter int DROP_W = PMUX_DROP_W
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic [WIDTH-1:0]           data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [DROP_W-1:0]          drop_cnt_o,
   output logic                       overflow_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              ovf_q, ovf_d;
   logic              push, pop, reject;
   logic [WIDTH-1:0]  rdata;
   assign ready_o = count_q != CW'(DEPTH);
   assign valid_o = count_q != '0;
   assign push    = valid_i & ready_o;
   assign pop     = valid_o & ready_i;
   assign reject  = valid_i & ~ready_o;
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      drop_d   = (reject && drop_q != '1) ? drop_q + DROP_W'(1) : drop_q;
      ovf_d    = ovf_q | reject;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
      end
   pmux_fifo_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );
   // Stale storage is hidden while empty.
   assign data_o     = valid_o ? rdata : '0;
   assign count_o    = count_q;
   assign drop_cnt_o = drop_q;
   assign overflow_o = ovf_q;
endmodule

// File: tb/tb_pmux_result_fifo.sv
// tb_pmux_result_fifo: directed checks of pmux_result_fifo against a queue-based model.
module tb_pmux_result_fifo;
   localparam int DEPTH = 4;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [15:0] data_i = '0;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b0;
   logic        ready_o, valid_o, overflow_o;
   logic [15:0] data_o;
   logic [2:0]  count_o;
   logic [7:0]  drop_cnt_o;
   int total = 0;
   int bad = 0;
   bit chk_en = 0;
   logic [15:0] mq[$];
   int          m_drops = 0;
   bit          m_ovf = 0;

   pmux_result_fifo dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
      .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .count_o(count_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_step(bit v, logic [15:0] d, bit r);
      bit full = mq.size() == DEPTH;
      bit empty = mq.size() == 0;
      if (r && !empty) void'(mq.pop_front());
      if (v && !full) mq.push_back(d);
      if (v && full) begin
         m_ovf = 1;
         if (m_drops < 255) m_drops++;
      end
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_drops = 0;
      m_ovf = 0;
   endfunction

   always @(negedge clk_i)
      if (chk_en && !rst_i) begin
         check("m_count", 32'(count_o), 32'(mq.size()));
         check("m_valid", 32'(valid_o), 32'(mq.size() != 0));
         check("m_ready", 32'(ready_o), 32'(mq.size() != DEPTH));
         check("m_data", 32'(data_o), mq.size() != 0 ? 32'(mq[0]) : 32'h0);
         check("m_drops", 32'(drop_cnt_o), 32'(m_drops));
         check("m_ovf", 32'(overflow_o), 32'(m_ovf));
      end

   task automatic cyc(bit v, logic [15:0] d, bit r);
      valid_i = v; data_i = d; ready_i = r;
      @(posedge clk_i);
      model_step(v, d, r);
      @(negedge clk_i);
   endtask

   task automatic reset_checks(string tag);
      check({tag, "_count"}, 32'(count_o), 0);
      check({tag, "_valid"}, 32'(valid_o), 0);
      check({tag, "_ready"}, 32'(ready_o), 1);
      check({tag, "_data"}, 32'(data_o), 0);
      check({tag, "_drops"}, 32'(drop_cnt_o), 0);
      check({tag, "_ovf"}, 32'(overflow_o), 0);
   endtask

   task automatic do_reset(string tag);
      valid_i = 0; ready_i = 0;
      #2 rst_i = 1;
      model_reset();
      #1 reset_checks(tag);
      @(posedge clk_i);
      #2 rst_i = 0;
      @(negedge clk_i);
      chk_en = 1;
   endtask

   initial begin
      @(negedge clk_i);
      do_reset("rst0");
      // 1: three pushes, consumer stalled
      cyc(1, 16'h0001, 0); cyc(1, 16'h0002, 0); cyc(1, 16'h0003, 0);
      check("t1_count", 32'(count_o), 3);
      check("t1_data", 32'(data_o), 32'h0001);
      check("t1_valid", 32'(valid_o), 1);
      check("t1_ready", 32'(ready_o), 1);
      do_reset("rst1");
      // 2: fill, then overflow
      for (int i = 0; i < 4; i++) cyc(1, 16'(16'h0010 + i), 0);
      check("t2_full_ready", 32'(ready_o), 0);
      check("t2_full_count", 32'(count_o), 4);
      cyc(1, 16'h00FF, 0);
      check("t2_drops", 32'(drop_cnt_o), 1);
      check("t2_ovf", 32'(overflow_o), 1);
      check("t2_count", 32'(count_o), 4);
      check("t2_head", 32'(data_o), 32'h0010);
      // 3: full with push and pop together
      cyc(1, 16'h00AA, 1);
      check("t3_count", 32'(count_o), 3);
      check("t3_drops", 32'(drop_cnt_o), 2);
      check("t3_head", 32'(data_o), 32'h0011);
      for (int i = 1; i < 4; i++) begin
         check("t2_pop_order", 32'(data_o), 32'(16'h0010 + i));
         cyc(0, 16'h0, 1);
      end
      check("t2_empty_data", 32'(data_o), 0);
      check("t2_empty_valid", 32'(valid_o), 0);
      cyc(0, 16'h0, 1);
      check("t2_empty_pop_count", 32'(count_o), 0);
      do_reset("rst2");
      // 4: streaming 20 words
      for (int k = 0; k < 20; k++) begin
         cyc(1, 16'(16'h0100 + k), 1);
         check("t4_count", 32'(count_o), 1);
         check("t4_data", 32'(data_o), 32'(16'h0100 + k));
      end
      cyc(0, 16'h0, 1);
      check("t4_drain", 32'(count_o), 0);
      check("t4_drops", 32'(drop_cnt_o), 0);
      // 5: saturating drop counter
      for (int i = 0; i < 4; i++) cyc(1, 16'(16'h0200 + i), 0);
      for (int i = 0; i < 300; i++) begin
         cyc(1, 16'hDEAD, 0);
         if (i == 254) check("t5_at255", 32'(drop_cnt_o), 255);
      end
      check("t5_sat", 32'(drop_cnt_o), 255);
      check("t5_ovf", 32'(overflow_o), 1);
      check("t5_count", 32'(count_o), 4);
      check("t5_head", 32'(data_o), 32'h0200);
      // stability of head while stalled
      cyc(0, 16'h0, 0);
      check("t5_stable", 32'(data_o), 32'h0200);
      // 6: asynchronous reset mid-cycle
      do_reset("rst3");
      cyc(1, 16'h0301, 0); cyc(1, 16'h0302, 0);
      check("t6_pre_count", 32'(count_o), 2);
      do_reset("t6_async");
      cyc(1, 16'hBEEF, 0);
      check("t6_data", 32'(data_o), 32'hBEEF);
      check("t6_count", 32'(count_o), 1);
      cyc(0, 16'h0, 1);
      check("t6_empty", 32'(valid_o), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
